// File: rtl/serial_rx_deframer_pkg.sv
// Shared UART framing definitions: FSM state encoding, bit-timing helpers and
// parity-mode constants, reused by the receive deframer and the transmit framer.
package serial_rx_deframer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Clock cycles per bit, rounded to nearest.
  function automatic int calc_bit_ticks(input int clk_freq, input int baud_rate);
    return (clk_freq + baud_rate / 2) / baud_rate;
  endfunction

  function automatic int calc_half(input int bit_ticks);
    return bit_ticks / 2;
  endfunction

endpackage

// File: rtl/serial_baud_sampler.sv
// Bit-period timer for the receive deframer: a down-counter that strobes
// 'sample' at terminal count, reloading with a half or full bit period.
module serial_baud_sampler
  import serial_rx_deframer_pkg::*;
#(
  parameter int BIT_TICKS = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic half_mode,
  output logic sample
);

  localparam int HALF = calc_half(BIT_TICKS);
  localparam int CW   = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam logic [CW-1:0] TC_FULL = CW'(BIT_TICKS - 1);
  localparam logic [CW-1:0] TC_HALF = CW'(HALF - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] reload;

  // half_mode picks the length of the interval that starts at the next reload.
  assign reload = half_mode ? TC_HALF : TC_FULL;
  assign sample = !restart && (cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart || sample) begin
      cnt <= reload;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/serial_rx_deframer.sv
// UART receive deframer: synchronises rx, validates start, shifts 8 data bits
// LSB-first, checks parity and stop, and hands bytes out over valid/ready.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   IDLE       | line idle, waiting for a low on rx_s
//   START      | half-bit wait, then confirm the start bit is still low
//   DATA       | sampling 8 data bits at mid-bit
//   PARITY     | sampling the parity bit
//   STOP       | sampling the stop bit and delivering the frame
//   WAIT_IDLE  | stop bit was low; wait for the line to return high
module serial_rx_deframer
  import serial_rx_deframer_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int   BIT_TICKS = calc_bit_ticks(CLK_FREQ, BAUD_RATE);
  localparam logic PAR_MODE  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  logic      rx_m, rx_s;
  rx_state_t state;
  logic [7:0] shreg;
  logic [2:0] bit_idx;
  logic       perr_q;
  logic       restart, half_mode, sample;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Timer is held while idle so the start window is measured from the edge.
  assign restart   = (state == ST_IDLE) || (state == ST_WAIT_IDLE);
  assign half_mode = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  serial_baud_sampler #(
    .BIT_TICKS(BIT_TICKS)
  ) u_sampler (
    .clk      (clk),
    .rst      (rst),
    .restart  (restart),
    .half_mode(half_mode),
    .sample   (sample)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_idx    <= '0;
      perr_q     <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state <= ST_START;
          end
        end
        ST_START: begin
          if (sample) begin
            bit_idx <= '0;
            perr_q  <= 1'b0;
            state   <= rx_s ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (sample) begin
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          if (sample) begin
            perr_q <= (((^shreg) ^ rx_s) != PAR_MODE);
            state  <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (sample) begin
            // A new byte may replace one that is being consumed this same cycle.
            if (!rx_valid || rx_ready) begin
              rx_data    <= shreg;
              parity_err <= perr_q;
              frame_err  <= !rx_s;
              rx_valid   <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
            state <= rx_s ? ST_IDLE : ST_WAIT_IDLE;
          end
        end
        ST_WAIT_IDLE: begin
          if (rx_s) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx_deframer.sv
// Self-checking bench for serial_rx_deframer: table of frames plus directed
// sequences for frame error, glitch, overrun and asynchronous reset.
module tb_serial_rx_deframer;

  localparam int BT   = 434;
  localparam int HALF = 217;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun, busy;

  always #5 clk = ~clk;

  serial_rx_deframer dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       pflip;
    logic       stop_b;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[5];

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   rise_cnt = 0;
  int   rise_cyc = 0;
  int   ov_cnt = 0;
  int   frame_t0 = 0;
  int   rc, ov0, lat, n;
  logic prev_valid = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every valid&ready cycle is one transfer matched against the queue.
  initial forever begin
    @(negedge clk);
    if (rx_valid && !prev_valid) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    prev_valid = rx_valid;
    if (overrun) ov_cnt++;
    if (rx_valid && rx_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL xfer_unexpected: got data=%02h perr=%0b ferr=%0b, expected no transfer",
                 rx_data, parity_err, frame_err);
      end else begin
        mon_e = exp_q.pop_front();
        if (rx_data !== mon_e.data || parity_err !== mon_e.perr || frame_err !== mon_e.ferr) begin
          fails++;
          $display("FAIL xfer: got data=%02h perr=%0b ferr=%0b, expected data=%02h perr=%0b ferr=%0b",
                   rx_data, parity_err, frame_err, mon_e.data, mon_e.perr, mon_e.ferr);
        end
      end
    end
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(BT);
  endtask

  // Even parity is sent correctly unless pflip; rx is left at the stop level.
  task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop_b);
    frame_t0 = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((^d) ^ pflip);
    send_bit(stop_b);
  endtask

  initial begin
    vecs[0] = '{8'h41, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0};
    vecs[1] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{8'hC3, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1};

    tick(5);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {overrun, parity_err, frame_err}, 0);
    rst = 1'b1;
    tick(10);

    rc = rise_cnt;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back('{vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr});
      send_frame(vecs[i].data, vecs[i].pflip, vecs[i].stop_b);
      if (i == 0) begin
        lat = rise_cyc - frame_t0;
        tests++;
        if (lat < 4558 || lat > 4562) begin
          fails++;
          $display("FAIL latency: got %0d cycles, expected 4559..4561 (+-1)", lat);
        end
      end
      rx = 1'b1;
      tick(2 * BT);
      check("vec_drain", exp_q.size(), 0);
      check("vec_busy_idle", busy, 0);
    end
    check("vec_rise_count", rise_cnt - rc, 5);

    // Stop bit low, line held low, then a clean frame.
    rc = rise_cnt;
    exp_q.push_back('{8'hA5, 1'b0, 1'b1});
    send_frame(8'hA5, 1'b0, 1'b0);
    tick(20 * BT);
    check("ferr_wait_busy", busy, 1);
    check("ferr_one_byte", rise_cnt - rc, 1);
    check("ferr_drain", exp_q.size(), 0);
    rx = 1'b1;
    tick(2 * BT);
    check("ferr_release_idle", busy, 0);
    exp_q.push_back('{8'h01, 1'b0, 1'b0});
    send_frame(8'h01, 1'b0, 1'b1);
    tick(BT);
    check("after_ferr_drain", exp_q.size(), 0);
    check("after_ferr_rises", rise_cnt - rc, 2);

    // Start-bit glitch.
    rc = rise_cnt;
    rx = 1'b0;
    tick(100);
    rx = 1'b1;
    n = 0;
    while (busy && n < HALF + 3) begin
      tick(1);
      n++;
    end
    check("glitch_busy", busy, 0);
    tick(BT);
    check("glitch_no_valid", rise_cnt - rc, 0);

    // Back-to-back frames with the consumer stalled.
    rx_ready = 1'b0;
    rc = rise_cnt;
    ov0 = ov_cnt;
    exp_q.push_back('{8'h10, 1'b0, 1'b0});
    send_frame(8'h10, 1'b0, 1'b1);
    send_frame(8'h20, 1'b0, 1'b1);
    rx = 1'b1;
    tick(BT);
    check("ovr_valid_held", rx_valid, 1);
    check("ovr_data_held", rx_data, 8'h10);
    check("ovr_pulse_cycles", ov_cnt - ov0, 1);
    check("ovr_rises", rise_cnt - rc, 1);
    rx_ready = 1'b1;
    tick(1);
    check("ovr_valid_drop", rx_valid, 0);
    check("ovr_drain", exp_q.size(), 0);

    // Asynchronous reset mid-frame while a byte is pending.
    rx_ready = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b1);
    rx = 1'b1;
    tick(20);
    check("pre_rst_valid", rx_valid, 1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'((8'h33 >> i) & 8'h01));
    rx = 1'b1;
    tick(200);
    rst = 1'b0;
    #1;
    check("async_rst_valid", rx_valid, 0);
    check("async_rst_data", rx_data, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_flags", {overrun, parity_err, frame_err}, 0);
    tick(3);
    rst = 1'b1;
    rx_ready = 1'b1;
    tick(2 * BT);
    check("post_rst_idle", busy, 0);
    exp_q.push_back('{8'h7E, 1'b0, 1'b0});
    send_frame(8'h7E, 1'b0, 1'b1);
    tick(BT);
    check("post_rst_drain", exp_q.size(), 0);
    check("post_rst_valid_low", rx_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
